// File: rtl/one_into_two_panner_pkg.sv
// Shared constants and FSM encoding for the mono-to-stereo panner.
// The accept/MUL/DONE sequence and gain widths are fixed by the 8-bit pan law.
package one_into_two_panner_pkg;

  localparam int SUPPORTED_PAN_BITS = 8;
  localparam int GAIN_BITS          = 9;
  localparam int IDX_BITS           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int midpoint(input int data_bits);
    return 1 << (data_bits - 1);
  endfunction

endpackage

// File: rtl/one_into_two_panner_serial_gain_multiplier.sv
// Signed sample times unsigned gain, one gain bit per step, no hardware multiplier.
// The parent sequences clear/step and supplies the bit index.
module serial_gain_multiplier
  import one_into_two_panner_pkg::*;
#(
  parameter int DATA_BITS = 12,
  parameter int ACC_BITS  = DATA_BITS + 10
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        step,
  input  logic [IDX_BITS-1:0]         bit_idx,
  input  logic signed [DATA_BITS-1:0] sample,
  input  logic [GAIN_BITS-1:0]        gain,
  output logic signed [ACC_BITS-1:0]  acc
);

  logic signed [ACC_BITS-1:0] addend;

  always_comb begin
    addend = '0;
    if (gain[bit_idx]) begin
      addend = ACC_BITS'(sample) <<< bit_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc + addend;
    end
  end

endmodule

// File: rtl/one_into_two_panner.sv
// Mono voice sample to left/right pair with programmable pan position.
// Fixed 10-cycle latency: accept, nine shift-add steps, then output register.
module one_into_two_panner
  import one_into_two_panner_pkg::*;
#(
  parameter int DATA_BITS = 12,
  parameter int PAN_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic [PAN_BITS-1:0]  pan,
  input  logic                 sample_valid,
  output logic                 busy,
  output logic [DATA_BITS-1:0] dout_l,
  output logic [DATA_BITS-1:0] dout_r,
  output logic                 dout_valid,
  output logic                 overrun
);

  localparam int ACC_BITS = DATA_BITS + 10;
  localparam logic [DATA_BITS-1:0]       MID     = DATA_BITS'(midpoint(DATA_BITS));
  localparam logic signed [ACC_BITS-1:0] MID_ACC = ACC_BITS'(midpoint(DATA_BITS));

  generate
    if (PAN_BITS != SUPPORTED_PAN_BITS) begin : g_bad_pan_bits
      $error("one_into_two_panner: PAN_BITS must be 8");
    end
  endgenerate

  // Floor-scale the product back by 256 and restore the offset-binary midpoint.
  function automatic logic [DATA_BITS-1:0] to_offset(input logic signed [ACC_BITS-1:0] p);
    return DATA_BITS'((p >>> SUPPORTED_PAN_BITS) + MID_ACC);
  endfunction

  state_t                      state, state_nxt;
  logic [IDX_BITS-1:0]         bit_idx;
  logic signed [DATA_BITS-1:0] s;
  logic [GAIN_BITS-1:0]        gain_l, gain_r;
  logic signed [ACC_BITS-1:0]  acc_l, acc_r;
  logic                        accept;
  logic                        step;

  assign accept = sample_valid && (state == IDLE);
  assign step   = (state == MUL);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_valid) state_nxt = MUL;
      MUL:     if (bit_idx == IDX_BITS'(GAIN_BITS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_idx    <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      dout_valid <= 1'b0;
      dout_l     <= MID;
      dout_r     <= MID;
    end else begin
      state      <= state_nxt;
      dout_valid <= 1'b0;
      if (sample_valid && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sample_valid) begin
            bit_idx <= '0;
            busy    <= 1'b1;
          end
        end
        MUL: bit_idx <= bit_idx + 1'b1;
        DONE: begin
          dout_l     <= to_offset(acc_l);
          dout_r     <= to_offset(acc_r);
          dout_valid <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Operand capture: flipping the midpoint offset yields the signed sample.
  always_ff @(posedge clk) begin
    if (accept) begin
      s      <= $signed(din - MID);
      gain_r <= GAIN_BITS'(pan);
      gain_l <= GAIN_BITS'(9'd256 - GAIN_BITS'(pan));
    end
  end

  serial_gain_multiplier #(
    .DATA_BITS (DATA_BITS),
    .ACC_BITS  (ACC_BITS)
  ) u_mul_l (
    .clk     (clk),
    .clear   (accept),
    .step    (step),
    .bit_idx (bit_idx),
    .sample  (s),
    .gain    (gain_l),
    .acc     (acc_l)
  );

  serial_gain_multiplier #(
    .DATA_BITS (DATA_BITS),
    .ACC_BITS  (ACC_BITS)
  ) u_mul_r (
    .clk     (clk),
    .clear   (accept),
    .step    (step),
    .bit_idx (bit_idx),
    .sample  (s),
    .gain    (gain_r),
    .acc     (acc_r)
  );

endmodule
